// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state type, the per-digit flag encodings and the BCD maximum helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [1:0] FLAG_SHOW  = 2'b00;
    localparam logic [1:0] FLAG_BLANK = 2'b01;

    // Largest value representable in the given number of BCD digits, 10^digits - 1.
    function automatic longint unsigned bcd_max(input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle.
// Optional leading-zero blanking flags are enabled by defining LEADING_ZERO_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      valor,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digitos,
    output logic [2*DIGITS-1:0]   flags,
    output logic                  overflow
);

    localparam int ACC_W = 4*DIGITS + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
    // Inputs too narrow to ever exceed the BCD range never need the overflow path.
    localparam bit CAN_OVERFLOW = (WIDTH >= 64) ||
                                  (((64'd1 << WIDTH) - 64'd1) > 64'(bcd_max(DIGITS)));

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [2*DIGITS-1:0] FLAGS_RESET = {{(DIGITS-1){FLAG_BLANK}}, FLAG_SHOW};
`else
    localparam logic [2*DIGITS-1:0] FLAGS_RESET = {DIGITS{FLAG_SHOW}};
`endif

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic [ACC_W-1:0]    acc;
    logic [4*DIGITS-1:0] acc_adj;
    logic [WIDTH-1:0]    value;
    logic [CNT_W-1:0]    count;
    logic                sticky;
    logic                result_ovf;
    logic [4*DIGITS-1:0] result_digits;
    logic [2*DIGITS-1:0] result_flags;

    // A start coinciding with the done pulse is dropped, hence the !done term.
    assign accept = (state == IDLE) && start && !done;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit    (acc[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == CNT_ONE) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Anything carried past the top digit, now or in an earlier shift, means the value is out of range.
    assign result_ovf    = CAN_OVERFLOW && (sticky || acc[ACC_W-1]);
    assign result_digits = result_ovf ? ALL_NINES : acc[4*DIGITS-1:0];

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nonzero;

    always_comb begin
        result_flags = {DIGITS{FLAG_SHOW}};
        seen_nonzero = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (!seen_nonzero && (result_digits[4*i +: 4] == 4'd0)) begin
                result_flags[2*i +: 2] = FLAG_BLANK;
            end else begin
                seen_nonzero = 1'b1;
            end
        end
    end
`else
    assign result_flags = {DIGITS{FLAG_SHOW}};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            value    <= '0;
            count    <= '0;
            sticky   <= 1'b0;
            done     <= 1'b0;
            digitos  <= '0;
            flags    <= FLAGS_RESET;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        value  <= valor;
                        acc    <= '0;
                        count  <= CNT_LOAD;
                        sticky <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc    <= {acc_adj, value[WIDTH-1]};
                    value  <= value << 1;
                    sticky <= sticky || acc[ACC_W-1];
                    count  <= count - CNT_ONE;
                end
                FINISH: begin
                    digitos  <= result_digits;
                    flags    <= result_flags;
                    overflow <= result_ovf;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard testbench for bin2bcd_seq (WIDTH=14, DIGITS=4): expectations come from
// a decimal-arithmetic reference model and are checked by a monitor on each done pulse.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] valor;
    logic        busy;
    logic        done;
    logic [15:0] digitos;
    logic [7:0]  flags;
    logic        overflow;

    typedef struct {
        logic [15:0] dig;
        logic [7:0]  fl;
        logic        ov;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    int unsigned cycle = 0;
    int          total = 0;
    int          passed = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] RESET_FLAGS = 8'b01010100;
`else
    localparam logic [7:0] RESET_FLAGS = 8'h00;
`endif

    bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .valor    (valor),
        .busy     (busy),
        .done     (done),
        .digitos  (digitos),
        .flags    (flags),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference: decimal digits by division, saturation above 9999, blanking of
    // every digit position whose weight exceeds the value.
    function automatic exp_t model(input int v);
        exp_t e;
        int   p;
        e.dig = '0;
        e.fl  = '0;
        e.ov  = (v > 9999);
        e.cyc = 0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            e.dig[4*i +: 4] = e.ov ? 4'd9 : 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && v < p) e.fl[2*i +: 2] = 2'b01;
`endif
            p = p * 10;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end else begin
            passed++;
        end
    endtask

    task automatic applyStimulus(input int v);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1;
        valor = 14'(v);
        e = model(v);
        e.cyc = cycle + 16;
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("digitos", 32'(digitos), 32'(e.dig));
                checkOutput("flags", 32'(flags), 32'(e.fl));
                checkOutput("overflow", 32'(overflow), 32'(e.ov));
                checkOutput("latency", cycle, e.cyc);
                checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int directed[7] = '{1234, 7, 0, 16383, 9999, 10000, 1};
        reset = 1'b1;
        start = 1'b0;
        valor = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_digitos", 32'(digitos), 32'd0);
        checkOutput("reset_flags", 32'(flags), 32'(RESET_FLAGS));
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        foreach (directed[i]) begin
            applyStimulus(directed[i]);
            waitDone();
        end

        repeat (5) @(negedge clk);
        checkOutput("hold_digitos", 32'(digitos), 32'(last_exp.dig));
        checkOutput("hold_flags", 32'(flags), 32'(last_exp.fl));
        checkOutput("hold_overflow", 32'(overflow), 32'(last_exp.ov));

        // start raised in the same cycle as done must not launch a conversion
        applyStimulus(56);
        waitDone();
        start = 1'b1;
        valor = 14'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("start_on_done_ignored", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);

        // starts while busy are dropped: only one done for 1234
        applyStimulus(1234);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        valor = 14'd99;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_during_shift", 32'(busy), 32'd1);
        waitDone();
        // back-to-back start on the cycle after done
        applyStimulus(8765);
        waitDone();
        repeat (20) @(negedge clk);

        // reset mid-conversion aborts with no done pulse
        applyStimulus(4321);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_digitos", 32'(digitos), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (25) @(negedge clk);
        applyStimulus(4321);
        waitDone();

        for (int n = 0; n < 24; n++) begin
            int v;
            if (n % 4 == 0) v = int'($urandom_range(9990, 10010));
            else            v = int'($urandom_range(0, 16383));
            applyStimulus(v);
            waitDone();
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 14: bit width of the binary input.
REQ-002 Parameter DIGITS, default 4: number of BCD digits produced.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to convert `valor`; sampled only in IDLE.
REQ-006 valor  input  WIDTH  unsigned binary value to convert.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  single-cycle pulse when new digits are valid.
REQ-009 digitos  output  4*DIGITS  BCD digits; digit 0 (units) in bits [3:0].
REQ-010 flags  output  2*DIGITS  per-digit blank flag, digit i in bits [2i+1:2i]; 2'b00 = show, 2'b01 = blank.
REQ-011 overflow  output  1  high when the last accepted `valor` exceeded 10^DIGITS-1.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT and FINISH.
REQ-013 In IDLE with start=1, the block SHALL latch `valor`, clear the BCD accumulator, load the shift counter with WIDTH, set busy, and enter SHIFT.
REQ-014 In SHIFT, each cycle SHALL apply add-3 to every accumulator digit >= 5, then shift {accumulator, value} left by one bit and decrement the counter.
REQ-015 When the counter reaches 0 after the last shift, the block SHALL enter FINISH.
REQ-016 In FINISH, the block SHALL register digitos, flags and overflow, pulse done for exactly one cycle, clear busy, and return to IDLE.
REQ-017 Latency from the start-sampling edge to done=1 SHALL be exactly WIDTH+1 cycles; busy SHALL be high for those WIDTH+1 cycles.
REQ-018 start SHALL be ignored while busy=1; no queuing.
REQ-019 A start in the same cycle as done SHALL be ignored; the earliest accepted start is the cycle after done.
REQ-020 If the latched valor > 10^DIGITS-1, digitos SHALL saturate to all 9s and overflow SHALL be 1; otherwise overflow SHALL be 0.
REQ-021 digitos, flags and overflow SHALL hold their values between done pulses.
REQ-022 The accumulator SHALL be 4*DIGITS+1 bits wide; the carry bit is used only for overflow detection.

Reset
REQ-023 reset=1 SHALL immediately force IDLE, busy=0, done=0, overflow=0 and digitos=0.
REQ-024 reset=1 SHALL force flags to the idle pattern defined in REQ-026/REQ-027.
REQ-025 reset asserted mid-conversion SHALL abort the conversion; no done pulse SHALL follow for it.

Configuration
REQ-026 With LEADING_ZERO_BLANK_EN defined, flags SHALL be 2'b01 for every zero digit above the most significant nonzero digit; digit 0 SHALL never be blanked; the reset pattern SHALL blank all digits except digit 0.
REQ-027 Without LEADING_ZERO_BLANK_EN, flags SHALL always be 2'b00 and the blanking logic SHALL be absent.

Structure
REQ-028 A shared package bin2bcd_pkg SHALL hold the FSM state typedef, the flag encodings FLAG_SHOW/FLAG_BLANK, and the function for the BCD maximum, 10^DIGITS-1.
REQ-029 The per-digit correction SHALL be a sub-module bcd_add3, with a 4-bit input and a 4-bit output, instantiated DIGITS times.

Verification (WIDTH=14, DIGITS=4, LEADING_ZERO_BLANK_EN defined unless stated)
REQ-030 Reset, then start with valor=1234 -> done 15 cycles later, digitos=16'h1234, flags=8'b00000000, overflow=0.
REQ-031 valor=7 -> digitos=16'h0007, flags=8'b01010100; without the macro, flags=8'h00.
REQ-032 valor=0 -> digitos=16'h0000, flags=8'b01010100; valor=16383 -> digitos=16'h9999, overflow=1.
REQ-033 start pulses on cycles 3 and 8 after an accepted start -> both ignored, one done only; back-to-back start on the cycle after done -> accepted.
REQ-034 reset asserted at SHIFT cycle 6 of valor=4321 -> busy=0 immediately, no done, digitos=0; the next conversion of 4321 is correct.
